// File: rtl/pll_lock_supervisor.sv
// PLL bring-up sequencer on the reference clock: pulses the PLL reset, qualifies
// lock over a stability window, then releases the SDRAM and core resets in order.
module pll_lock_supervisor #(
  parameter int unsigned RST_PULSE    = 16,
  parameter int unsigned LOCK_STABLE  = 1024,
  parameter int unsigned SDRAM_DELAY  = 256,
  parameter int unsigned LOCK_TIMEOUT = 1048576
) (
  input  logic       refclk,
  input  logic       reset,
  input  logic       locked_in,
  output logic       pll_rst,
  output logic       rst_sdram,
  output logic       rst_core,
  output logic [2:0] state,
  output logic [7:0] loss_count,
  output logic [7:0] retry_count
);

  localparam int unsigned MAX_AB = (RST_PULSE > LOCK_STABLE) ? RST_PULSE : LOCK_STABLE;
  localparam int unsigned MAX_CD = (SDRAM_DELAY > LOCK_TIMEOUT) ? SDRAM_DELAY : LOCK_TIMEOUT;
  localparam int unsigned MAX_P  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int unsigned CW     = (MAX_P > 1) ? $clog2(MAX_P) : 1;

  localparam logic [CW-1:0] CNT_ZERO     = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE      = CW'(1);
  localparam logic [CW-1:0] RST_LAST     = CW'(RST_PULSE - 1);
  localparam logic [CW-1:0] STABLE_LAST  = CW'(LOCK_STABLE - 1);
  localparam logic [CW-1:0] SDRAM_LAST   = CW'(SDRAM_DELAY - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_RESET_PLL = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RUN_SDRAM = 3'd3,
    S_RUN       = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    loss_q, loss_d;
  logic [7:0]    retry_q, retry_d;
  logic          sync1_q, lk_q;
  logic          pll_rst_q, rst_sdram_q, rst_core_q;

  // Next-state logic; loss of lock is checked before the counter terminal so a drop always wins
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    loss_d  = loss_q;
    retry_d = retry_q;
    case (state_q)
      S_RESET_PLL: begin
        if (cnt_q == RST_LAST) begin
          state_d = S_WAIT_LOCK;
          cnt_d   = CNT_ZERO;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_WAIT_LOCK: begin
        if (lk_q) begin
          state_d = S_STABLE;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d = S_RESET_PLL;
          cnt_d   = CNT_ZERO;
          retry_d = (retry_q == 8'hFF) ? retry_q : retry_q + 8'd1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_STABLE: begin
        if (!lk_q) begin
          state_d = S_WAIT_LOCK;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = S_RUN_SDRAM;
          cnt_d   = CNT_ZERO;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_RUN_SDRAM: begin
        if (!lk_q) begin
          state_d = S_RESET_PLL;
          cnt_d   = CNT_ZERO;
          loss_d  = (loss_q == 8'hFF) ? loss_q : loss_q + 8'd1;
        end else if (cnt_q == SDRAM_LAST) begin
          state_d = S_RUN;
          cnt_d   = CNT_ZERO;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_RUN: begin
        // Counter holds here so it can never wrap during a long run
        if (!lk_q) begin
          state_d = S_RESET_PLL;
          cnt_d   = CNT_ZERO;
          loss_d  = (loss_q == 8'hFF) ? loss_q : loss_q + 8'd1;
        end else begin
          cnt_d = cnt_q;
        end
      end
      default: begin
        state_d = S_RESET_PLL;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  // State, counters, lock synchronizer and output registers
  always_ff @(posedge refclk) begin
    if (reset) begin
      state_q     <= S_RESET_PLL;
      cnt_q       <= CNT_ZERO;
      loss_q      <= 8'd0;
      retry_q     <= 8'd0;
      sync1_q     <= 1'b0;
      lk_q        <= 1'b0;
      pll_rst_q   <= 1'b1;
      rst_sdram_q <= 1'b1;
      rst_core_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      loss_q      <= loss_d;
      retry_q     <= retry_d;
      sync1_q     <= locked_in;
      lk_q        <= sync1_q;
      // Outputs decode the next state so they change on the same edge as the state
      pll_rst_q   <= (state_d == S_RESET_PLL);
      rst_sdram_q <= !((state_d == S_RUN_SDRAM) || (state_d == S_RUN));
      rst_core_q  <= (state_d != S_RUN);
    end
  end

  assign pll_rst     = pll_rst_q;
  assign rst_sdram   = rst_sdram_q;
  assign rst_core    = rst_core_q;
  assign state       = state_q;
  assign loss_count  = loss_q;
  assign retry_count = retry_q;

endmodule
